// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the boot loader.
// The master side is the byte source / RAM observer; the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [15:0]           din;
    logic                  w_en;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  w_addr,
        input  din,
        input  w_en
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output w_addr,
        output din,
        output w_en
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses one framed image from a byte
// stream (SYNC, LEN_HI, LEN_LO, N x {HI, LO}, CSUM), writes it as 16-bit words
// and holds the CPU in reset until an image with a matching checksum is in RAM.
module imem_loader #(
    parameter int                     ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int                     MAX_WORDS  = 4096,
    parameter logic [7:0]             SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [7:0]            r_hi;
    logic [15:0]           r_count;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [15:0]           r_din;
    logic                  r_w_en;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;

    logic                  w_xfer;
    logic [15:0]           w_len;
    logic                  w_sync;

    // WRITE is the only cycle in which no byte can be taken
    assign bus.rx_ready = (r_state != WRITE);
    assign w_xfer       = bus.rx_valid && bus.rx_ready;
    assign w_len        = {r_len_hi, bus.rx_data};
    assign w_sync       = (bus.rx_data == SYNC_BYTE);

    assign bus.w_addr   = r_w_addr;
    assign bus.din      = r_din;
    assign bus.w_en     = r_w_en;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;

    // Frame parser, word writer and status outputs, all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len_hi   <= 8'h00;
            r_hi       <= 8'h00;
            r_count    <= 16'h0000;
            r_csum     <= 8'h00;
            r_w_addr   <= BASE_ADDR;
            r_din      <= 16'h0000;
            r_w_en     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    // A sync byte (re)starts a frame from any resting state;
                    // everything else is consumed and dropped.
                    if (w_xfer && w_sync) begin
                        r_state    <= LEN_HI;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_csum     <= 8'h00;
                        r_w_addr   <= BASE_ADDR;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= bus.rx_data;
                        r_state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_count <= w_len;
                        if (w_len == 16'h0000) begin
                            r_state <= CSUM;
                        end else if (w_len > MAX_LEN) begin
                            r_state    <= ERROR;
                            r_error    <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end else begin
                            r_state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (w_xfer) begin
                        r_hi    <= bus.rx_data;
                        r_csum  <= r_csum + bus.rx_data;
                        r_state <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (w_xfer) begin
                        r_csum  <= r_csum + bus.rx_data;
                        r_din   <= {r_hi, bus.rx_data};
                        r_w_en  <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    // Strobe lasts exactly this cycle; address moves on the exit edge
                    r_w_en   <= 1'b0;
                    r_w_addr <= r_w_addr + ADDR_WIDTH'(1);
                    r_count  <= r_count - 16'd1;
                    if (r_count == 16'd1) begin
                        r_state <= CSUM;
                    end else begin
                        r_state <= DATA_HI;
                    end
                end
                CSUM: begin
                    if (w_xfer) begin
                        if (bus.rx_data == r_csum) begin
                            r_state    <= DONE;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state    <= ERROR;
                            r_cpu_hold <= 1'b1;
                            r_error    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
